// File: rtl/spmv_result_drain_if.sv
// Beat-level bus of spmv_result_drain: paired results in from the multiplier,
// serialised single results out to the host with a valid/ready handshake.
interface spmv_result_drain_if #(
    parameter int ROW_W  = 10,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              zeros;
    logic [ROW_W-1:0]  addrext;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output valid, zeros, addrext, op1, op2, out_ready,
        input  out_data, out_row, out_valid
    );

    modport slave (
        input  valid, zeros, addrext, op1, op2, out_ready,
        output out_data, out_row, out_valid
    );
endinterface

// File: rtl/spmv_result_drain.sv
// Result drain for the SpMV multiplier: buffers paired row results and emits
// them one row per beat. Optional build macro: DRAIN_ZERO_SKIP_EN (drop zero beats).
module spmv_result_drain #(
    parameter int DEPTH  = 8,
    parameter int ROW_W  = 10,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    spmv_result_drain_if.slave  bus,
    input  logic                done_in,
    output logic                overflow,
    output logic                drain_done,
    output logic [15:0]         rows_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

    state_t            state;
    logic [ROW_W-1:0]  mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_op1   [DEPTH];
    logic [DATA_W-1:0] mem_op2   [DEPTH];
    logic              mem_zeros [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW:0]   count;
    logic          accept;
    logic          push;
    logic          drop;
    logic          pop;
    logic          handshake;

`ifdef DRAIN_ZERO_SKIP_EN
    assign accept = bus.valid && !bus.zeros;
`else
    assign accept = bus.valid;
`endif

    // Fullness uses the registered count only; a pop in the same cycle does not make room.
    assign push       = accept && (count < FULL);
    assign drop       = accept && (count == FULL);
    assign handshake  = (state != IDLE) && bus.out_ready;
    assign pop        = (state == EMIT_B) && bus.out_ready;
    assign rd_ptr_inc = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= bus.addrext;
            mem_op1[wr_ptr]   <= bus.op1;
            mem_op2[wr_ptr]   <= bus.op2;
            mem_zeros[wr_ptr] <= bus.zeros;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (done_in && (count == '0) && (state == IDLE) && !push) begin
                drain_done <= 1'b1;
            end
        end
    end

    // Outputs are loaded for the state being entered, so they are stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            rows_out      <= '0;
        end else begin
            if (handshake) begin
                rows_out <= rows_out + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state         <= EMIT_A;
                        bus.out_valid <= 1'b1;
                        bus.out_row   <= mem_addr[rd_ptr];
                        bus.out_data  <= mem_zeros[rd_ptr] ? '0 : mem_op1[rd_ptr];
                    end
                end
                EMIT_A: begin
                    if (bus.out_ready) begin
                        state         <= EMIT_B;
                        bus.out_valid <= 1'b1;
                        bus.out_row   <= mem_addr[rd_ptr] + ROW_W'(1);
                        bus.out_data  <= mem_zeros[rd_ptr] ? '0 : mem_op2[rd_ptr];
                    end
                end
                EMIT_B: begin
                    if (bus.out_ready) begin
                        if (count > (AW+1)'(1)) begin
                            state         <= EMIT_A;
                            bus.out_valid <= 1'b1;
                            bus.out_row   <= mem_addr[rd_ptr_inc];
                            bus.out_data  <= mem_zeros[rd_ptr_inc] ? '0 : mem_op1[rd_ptr_inc];
                        end else begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spmv_result_drain.sv
// Self-checking bench for spmv_result_drain: vector table, directed corner
// sequences and a randomized run against a queue-based result model.
module tb_spmv_result_drain;
    logic        clk;
    logic        reset;
    logic        done_in;
    logic        overflow;
    logic        drain_done;
    logic [15:0] rows_out;

    int total = 0;
    int bad   = 0;

    spmv_result_drain_if #(.ROW_W(10), .DATA_W(64)) bus ();

    spmv_result_drain #(.DEPTH(8), .ROW_W(10), .DATA_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .done_in    (done_in),
        .overflow   (overflow),
        .drain_done (drain_done),
        .rows_out   (rows_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        zeros;
        logic [9:0]  r0;
        logic [63:0] d0;
        logic [9:0]  r1;
        logic [63:0] d1;
    } vec_t;

    typedef struct {
        logic [9:0]  row;
        logic [63:0] data;
        bit          last;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic drive_beat(input logic [9:0] a, input logic [63:0] o1, input logic [63:0] o2,
                              input logic z);
        bus.valid   = 1'b1;
        bus.addrext = a;
        bus.op1     = o1;
        bus.op2     = o2;
        bus.zeros   = z;
    endtask

    initial begin
        int          exp_rows;
        int          n;
        int          hs;
        int          mcnt;
        bit          movf;
        logic [15:0] mrows;
        bit          prev_stall;
        logic [9:0]  prev_row;
        logic [63:0] prev_data;
        bit          v;
        bit          z;
        bit          eff;
        bit          push_ok;
        logic [9:0]  a;
        logic [63:0] o1;
        logic [63:0] o2;
        exp_t        e;

        vecs[0] = '{10'd5,    64'h11,   64'h22,   1'b0, 10'd5,    64'h11,   10'd6,    64'h22};
        vecs[1] = '{10'd1023, 64'hAAAA, 64'hBBBB, 1'b0, 10'd1023, 64'hAAAA, 10'd0,    64'hBBBB};
        vecs[2] = '{10'd40,   64'hFF,   64'h1234, 1'b1, 10'd40,   64'h0,    10'd41,   64'h0};
        vecs[3] = '{10'd0,    64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0,
                    10'd0,    64'hFFFF_FFFF_FFFF_FFFF, 10'd1, 64'h8000_0000_0000_0001};
        vecs[4] = '{10'd1022, 64'h1,    64'h2,    1'b0, 10'd1022, 64'h1,    10'd1023, 64'h2};
        vecs[5] = '{10'd1023, 64'hFF,   64'h77,   1'b1, 10'd1023, 64'h0,    10'd0,    64'h0};

        reset         = 1'b1;
        done_in       = 1'b0;
        bus.valid     = 1'b0;
        bus.zeros     = 1'b0;
        bus.addrext   = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_rows_out", rows_out, 0);
        tick();
        reset = 1'b0;
        tick();

        // Table: single beats, latency, row wrap and zero forcing.
        bus.out_ready = 1'b1;
        exp_rows = 0;
        for (int i = 0; i < 6; i++) begin
            drive_beat(vecs[i].addr, vecs[i].op1, vecs[i].op2, vecs[i].zeros);
            tick();
            bus.valid = 1'b0;
            check("vec_lat_n", bus.out_valid, 0);
            tick();
`ifdef DRAIN_ZERO_SKIP_EN
            if (vecs[i].zeros) begin
                check("vec_skip_v0", bus.out_valid, 0);
                tick();
                check("vec_skip_v1", bus.out_valid, 0);
                check("vec_skip_rows", rows_out, 16'(exp_rows));
                continue;
            end
`endif
            check("vec_a_valid", bus.out_valid, 1);
            check("vec_a_row", bus.out_row, vecs[i].r0);
            check("vec_a_data", bus.out_data, vecs[i].d0);
            tick();
            check("vec_b_valid", bus.out_valid, 1);
            check("vec_b_row", bus.out_row, vecs[i].r1);
            check("vec_b_data", bus.out_data, vecs[i].d1);
            tick();
            check("vec_end_valid", bus.out_valid, 0);
            exp_rows += 2;
            check("vec_rows_out", rows_out, 16'(exp_rows));
        end

        // Backpressure: held output stays stable, then one handshake per cycle.
        bus.out_ready = 1'b0;
        drive_beat(10'd100, 64'hA1, 64'hB2, 1'b0);
        tick();
        bus.valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.out_valid, 1);
            check("bp_row", bus.out_row, 10'd100);
            check("bp_data", bus.out_data, 64'hA1);
            tick();
        end
        check("bp_rows_held", rows_out, 16'(exp_rows));
        bus.out_ready = 1'b1;
        check("bp_rel_row_a", bus.out_row, 10'd100);
        tick();
        check("bp_rel_row_b", bus.out_row, 10'd101);
        check("bp_rel_data_b", bus.out_data, 64'hB2);
        check("bp_rel_rows_1", rows_out, 16'(exp_rows + 1));
        tick();
        check("bp_rel_end", bus.out_valid, 0);
        check("bp_rel_rows_2", rows_out, 16'(exp_rows + 2));

        // Overflow: nine beats into a stalled eight-entry FIFO.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive_beat(10'(200 + 3 * k), 64'(1000 + k), 64'(5000 + k), 1'b0);
            tick();
            if (k == 7) check("ovf_before", overflow, 0);
            if (k == 8) check("ovf_after", overflow, 1);
        end
        bus.valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                if (n < 16) begin
                    check("ovf_row", bus.out_row, 10'(200 + 3 * (n / 2) + (n % 2)));
                    check("ovf_data", bus.out_data, (n % 2) ? 64'(5000 + n / 2) : 64'(1000 + n / 2));
                end
                n++;
            end
            tick();
        end
        check("ovf_out_count", n, 16);
        check("ovf_sticky", overflow, 1);

        // Drain: done_in with three beats buffered.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_beat(10'(300 + 2 * k), 64'(k + 1), 64'(k + 11), 1'b0);
            tick();
        end
        bus.valid = 1'b0;
        done_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("drain_stalled", drain_done, 0);
        end
        bus.out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30 && hs < 6; c++) begin
            if (bus.out_valid) hs++;
            tick();
            check("drain_early", drain_done, 0);
        end
        check("drain_hs_count", hs, 6);
        tick();
        check("drain_rise", drain_done, 1);
        check("drain_rows", rows_out, 6);

        // Asynchronous reset in the middle of a stalled, overflowed stream.
        done_in = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive_beat(10'(k), 64'(k), 64'(k), 1'b0);
            tick();
        end
        bus.valid = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_ovf", overflow, 1);
        check("pre_rst_done", drain_done, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_rows", rows_out, 0);
        check("async_rst_ovf", overflow, 0);
        check("async_rst_done", drain_done, 0);
        check("async_rst_data", bus.out_data, 0);
        #2;
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_empty", bus.out_valid, 0);

        // Randomized traffic against a queue of expected results.
        do_reset();
        q.delete();
        mcnt = 0;
        movf = 1'b0;
        mrows = '0;
        prev_stall = 1'b0;
        prev_row = '0;
        prev_data = '0;
        for (int c = 0; c < 600; c++) begin
            if (prev_stall) begin
                check("rnd_hold_valid", bus.out_valid, 1);
                check("rnd_hold_row", bus.out_row, prev_row);
                check("rnd_hold_data", bus.out_data, prev_data);
            end
            v  = ($urandom_range(0, 99) < ((c >= 200 && c < 400) ? 80 : 35));
            z  = ($urandom_range(0, 99) < 15);
            a  = 10'($urandom);
            o1 = {$urandom, $urandom};
            o2 = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 99) < ((c >= 200 && c < 400) ? 30 : 75));
            if (v) drive_beat(a, o1, o2, z);
            else bus.valid = 1'b0;
`ifdef DRAIN_ZERO_SKIP_EN
            eff = v && !z;
`else
            eff = v;
`endif
            push_ok = eff && (mcnt < 8);
            if (eff && !push_ok) movf = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("rnd_row", bus.out_row, e.row);
                    check("rnd_data", bus.out_data, e.data);
                    if (e.last) mcnt--;
                end
                mrows++;
            end
            if (push_ok) begin
                q.push_back('{a, z ? 64'h0 : o1, 1'b0});
                q.push_back('{a + 10'd1, z ? 64'h0 : o2, 1'b1});
                mcnt++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_row   = bus.out_row;
            prev_data  = bus.out_data;
            tick();
            check("rnd_overflow", overflow, movf);
            check("rnd_rows_out", rows_out, mrows);
        end
        bus.valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            if (bus.out_valid) begin
                e = q.pop_front();
                check("fin_row", bus.out_row, e.row);
                check("fin_data", bus.out_data, e.data);
                mrows++;
            end
            tick();
        end
        check("fin_queue_empty", q.size(), 0);
        tick();
        check("fin_idle", bus.out_valid, 0);
        check("fin_rows_out", rows_out, mrows);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
